// File: rtl/pio_irq_ctrl.sv
// PIO interrupt servicing controller: masks in all PIO channels, then round-robin services
// edge-capture irqs (read pin, clear capture, emit event, hold off). Optional PIO_IRQ_CTRL_TIMESTAMP_EN.
module pio_irq_ctrl #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   pio_irq,
    output logic [1:0]        pio_address,
    output logic [N_CH-1:0]   pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    input  logic [32*N_CH-1:0] pio_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_channel,
    output logic              evt_level,
    output logic              busy
`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
    ,
    output logic [31:0]       evt_timestamp
`endif
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned HOLD_W = 16;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_ADDR, S_RD_CAP, S_CLR, S_EVENT, S_HOLD
    } state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   init_idx, init_idx_d;
    logic [CH_W-1:0]    last_grant, last_grant_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;

    logic               arb_found;
    logic [CH_W-1:0]    arb_win;
    logic               level_sel;
    logic               unused_rd;

    logic [1:0]         addr_d;
    logic [N_CH-1:0]    cs_d;
    logic               wn_d;
    logic [31:0]        wd_d;
    logic               valid_d;
    logic               busy_d;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            if (!arb_found && pio_irq[(32'(last_grant) + i) % N_CH]) begin
                arb_found = 1'b1;
                arb_win   = CH_W'((32'(last_grant) + i) % N_CH);
            end
        end
    end

    // Bit 0 (pin level) of the granted channel's readdata slice
    always_comb begin
        level_sel = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (last_grant == CH_W'(k)) level_sel = pio_readdata[32*k];
        end
    end

    assign unused_rd = ^pio_readdata;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            init_idx   <= '0;
            last_grant <= CH_W'(N_CH - 1);
            hold_cnt   <= '0;
        end else begin
            state      <= next_state;
            init_idx   <= init_idx_d;
            last_grant <= last_grant_d;
            hold_cnt   <= hold_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state   = state;
        init_idx_d   = init_idx;
        last_grant_d = last_grant;
        hold_cnt_d   = '0;
        case (state)
            S_INIT: begin
                if (init_idx == IDX_W'(N_CH)) next_state = S_IDLE;
                else                          init_idx_d = init_idx + 1'b1;
            end
            S_IDLE: begin
                if (arb_found) begin
                    next_state   = S_RD_ADDR;
                    last_grant_d = arb_win;
                end
            end
            S_RD_ADDR: next_state = S_RD_CAP;
            S_RD_CAP:  next_state = S_CLR;
            S_CLR:     next_state = S_EVENT;
            S_EVENT: begin
                if (evt_valid && evt_ready) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLDOFF - 1)) next_state = S_IDLE;
                else                                  hold_cnt_d = hold_cnt + 1'b1;
            end
            default: begin
                next_state = S_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // Output decode of the upcoming state; registered below so outputs line up with it
    always_comb begin
        addr_d  = 2'd0;
        cs_d    = '0;
        wn_d    = 1'b1;
        wd_d    = 32'h0;
        valid_d = 1'b0;
        busy_d  = (next_state != S_IDLE);
        case (next_state)
            S_INIT: begin
                if (state == S_INIT) begin
                    addr_d = 2'd2;
                    wn_d   = 1'b0;
                    wd_d   = 32'h1;
                    for (int unsigned k = 0; k < N_CH; k++)
                        cs_d[k] = (init_idx == IDX_W'(k));
                end
            end
            S_RD_ADDR: begin
                for (int unsigned k = 0; k < N_CH; k++)
                    cs_d[k] = (last_grant_d == CH_W'(k));
            end
            S_CLR: begin
                addr_d = 2'd3;
                wn_d   = 1'b0;
                for (int unsigned k = 0; k < N_CH; k++)
                    cs_d[k] = (last_grant_d == CH_W'(k));
            end
            S_EVENT: valid_d = 1'b1;
            default: ;
        endcase
    end

    // Registered bus and event outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_address    <= 2'd0;
            pio_chipselect <= '0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'h0;
            evt_valid      <= 1'b0;
            evt_channel    <= '0;
            evt_level      <= 1'b0;
            busy           <= 1'b1;
        end else begin
            pio_address    <= addr_d;
            pio_chipselect <= cs_d;
            pio_write_n    <= wn_d;
            pio_writedata  <= wd_d;
            evt_valid      <= valid_d;
            busy           <= busy_d;
            if (state == S_RD_CAP) begin
                evt_level   <= level_sel;
                evt_channel <= last_grant;
            end
        end
    end

`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter, sampled while the readback is captured
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt        <= 32'h0;
            evt_timestamp <= 32'h0;
        end else begin
            ts_cnt <= ts_cnt + 32'h1;
            if (state == S_RD_CAP) evt_timestamp <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Directed bench for pio_irq_ctrl: init mask writes, service latency, stall, mid-sequence reset,
// round-robin fairness and holdoff spacing.
module tb_pio_irq_ctrl;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned HOLDOFF = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N_CH-1:0]      pio_irq = '0;
    logic [N_CH-1:0]      pins = '0;
    logic [1:0]           pio_address;
    logic [N_CH-1:0]      pio_chipselect;
    logic                 pio_write_n;
    logic [31:0]          pio_writedata;
    logic [32*N_CH-1:0]   pio_readdata;
    logic                 evt_valid;
    logic                 evt_ready = 1'b0;
    logic [2:0]           evt_channel;
    logic                 evt_level;
    logic                 busy;
`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
    logic [31:0]          evt_timestamp;
    logic [31:0]          cyc;
    logic [31:0]          ts_exp;
`endif

    int vectors = 0;
    int errors  = 0;
    int n;

    pio_irq_ctrl #(.N_CH(N_CH), .HOLDOFF(HOLDOFF)) dut (
        .clk            (clk),
        .reset          (reset),
        .pio_irq        (pio_irq),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_channel    (evt_channel),
        .evt_level      (evt_level),
        .busy           (busy)
`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
        ,
        .evt_timestamp  (evt_timestamp)
`endif
    );

    always #5 clk = ~clk;

    // PIO model: registered readdata carrying the pin level in bit 0
    always @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) pio_readdata[32*k +: 32] <= {31'b0, pins[k]};
    end

`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 32'h0;
        else       cyc <= cyc + 32'h1;
    end
`endif

    function automatic logic [38:0] bus(input logic [1:0] a, input logic [3:0] cs,
                                        input logic wn, input logic [31:0] wd);
        return {a, cs, wn, wd};
    endfunction

    function automatic logic [38:0] bus_now();
        return {pio_address, pio_chipselect, pio_write_n, pio_writedata};
    endfunction

    localparam logic [38:0] BUS_IDLE = {2'd0, 4'b0000, 1'b1, 32'h0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        pio_readdata = '0;
        repeat (3) @(negedge clk);
        check("rst_bus", 64'(bus_now()), 64'(BUS_IDLE));
        check("rst_evt", 64'({evt_valid, evt_channel, evt_level, busy}), 64'({1'b0, 3'd0, 1'b0, 1'b1}));

        // Init: mask writes to channels 0..3 on consecutive cycles
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("init_wr", 64'(bus_now()), 64'(bus(2'd2, 4'(1 << i), 1'b0, 32'h1)));
        end
        @(negedge clk);
        check("init_done", 64'({busy, bus_now()}), 64'({1'b0, BUS_IDLE}));

        // Latency: irq on channel 2, event 4 cycles later; irq drops after grant
        pins = 4'b0100; evt_ready = 1'b1; pio_irq = 4'b0100;
`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
        ts_exp = cyc + 32'd2;
`endif
        @(negedge clk);
        check("lat_rd", 64'(bus_now()), 64'(bus(2'd0, 4'b0100, 1'b1, 32'h0)));
        pio_irq = '0;
        @(negedge clk);
        check("lat_cap", 64'({evt_valid, bus_now()}), 64'({1'b0, BUS_IDLE}));
        @(negedge clk);
        check("lat_clr", 64'(bus_now()), 64'(bus(2'd3, 4'b0100, 1'b0, 32'h0)));
        @(negedge clk);
        check("lat_evt", 64'({evt_valid, evt_channel, evt_level}), 64'({1'b1, 3'd2, 1'b1}));
`ifdef PIO_IRQ_CTRL_TIMESTAMP_EN
        check("lat_ts", 64'(evt_timestamp), 64'(ts_exp));
`endif
        @(negedge clk);
        check("lat_acc", 64'({evt_valid, busy}), 64'({1'b0, 1'b1}));
        repeat (HOLDOFF - 1) @(negedge clk);
        check("hold_end", 64'(busy), 64'(1'b1));
        @(negedge clk);
        check("hold_done", 64'({busy, bus_now()}), 64'({1'b0, BUS_IDLE}));

        // Stall: consumer not ready for 10 cycles
        pins = 4'b0000; evt_ready = 1'b0; pio_irq = 4'b0001;
        @(negedge clk);
        pio_irq = '0;
        repeat (3) @(negedge clk);
        check("stall_evt", 64'({evt_valid, evt_channel, evt_level}), 64'({1'b1, 3'd0, 1'b0}));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({evt_valid, evt_channel, evt_level, bus_now()}),
                  64'({1'b1, 3'd0, 1'b0, BUS_IDLE}));
        end
        evt_ready = 1'b1;
        @(negedge clk);
        check("stall_acc", 64'(evt_valid), 64'(1'b0));
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        check("stall_idle", 64'(busy), 64'(1'b0));

        // Reset during RD_CAP drops the event and reruns init
        pio_irq = 4'b0010; pins = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid", 64'({evt_valid, busy, bus_now()}), 64'({1'b0, 1'b1, BUS_IDLE}));
        pio_irq = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reinit_wr", 64'({evt_valid, bus_now()}), 64'({1'b0, bus(2'd2, 4'(1 << i), 1'b0, 32'h1)}));
        end
        @(negedge clk);
        check("reinit_done", 64'({evt_valid, busy}), 64'({1'b0, 1'b0}));

        // Fairness: all channels pending, order 0,1,2,3,0 spaced by holdoff
        pins = 4'b0110; evt_ready = 1'b1; pio_irq = 4'b1111;
        for (int e = 0; e < 5; e++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!evt_valid && n < 60);
            check("fair_evt", 64'({evt_valid, evt_channel, evt_level}),
                  64'({1'b1, 3'(e % 4), pins[e % 4]}));
            check("fair_gap", 64'(n), 64'((e == 0) ? 4 : HOLDOFF + 5));
        end
        pio_irq = '0;
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        check("fair_idle", 64'({busy, evt_valid}), 64'({1'b0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
